// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small FIFO of prefetched words.
// A redirect flushes the queue and any in-flight response; halt stops new fetches.
module fetch_queue #(
    parameter int AW    = 16,
    parameter int IW    = 9,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          init_n,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_target,
    input  logic          halt_in,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1) + 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t        state;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] req_pc;
    logic          inflight;
    logic [IW-1:0] q_data [DEPTH];
    logic [AW-1:0] q_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic          push;
    logic          pop;
    logic          issue;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Redirect gates valid/req combinationally so no handshake or issue completes that cycle.
    assign pending     = count + CW'(inflight);
    assign instr_valid = (count != '0) && !redirect;
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight && !redirect;
    assign issue       = init_n && (state == RUN) && !redirect && !halt_in
                         && ((pending - CW'(pop)) < CW'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign instr     = q_data[rd_ptr];
    assign instr_pc  = q_pc[rd_ptr];
    assign halted    = (state == HALT) && (count == '0) && !inflight;

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state    <= RUN;
            fetch_pc <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            if (halt_in)
                state <= HALT;

            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                inflight <= 1'b0;
                fetch_pc <= redirect_target;
            end else begin
                inflight <= issue;
                if (issue) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + AW'(1);
                end
                if (push) begin
                    q_data[wr_ptr] <= imem_data;
                    q_pc[wr_ptr]   <= req_pc;
                    wr_ptr         <= next_ptr(wr_ptr);
                end
                if (pop)
                    rd_ptr <= next_ptr(rd_ptr);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (!push && pop)
                    count <= count - CW'(1);
            end
        end
    end

    // Issue throttling guarantees room for every in-flight response.
    no_overflow: assert property (@(posedge CLK) disable iff (!init_n)
        (push && !pop) |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue; the memory returns mem[a] = a + 0x10.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        init_n = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = '0;
    logic        halt_in = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [8:0]  imem_data = '0;
    logic [8:0]  instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;

    int errors = 0;
    int checks = 0;
    int vidx   = -1;

    fetch_queue #(.AW(16), .IW(9), .DEPTH(2)) dut (
        .CLK(CLK), .init_n(init_n), .redirect(redirect), .redirect_target(redirect_target),
        .halt_in(halt_in), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted)
    );

    always #10 CLK = ~CLK;

    // Synchronous memory: data valid the cycle after the request.
    always @(posedge CLK) begin
        if (imem_req)
            imem_data <= 9'(imem_addr + 16'h0010);
        else
            imem_data <= 9'h1EE;
    end

    typedef struct {
        bit          rst;
        bit          redir;
        logic [15:0] tgt;
        bit          halt;
        bit          rdy;
        bit          e_req;
        logic [15:0] e_addr;
        bit          e_val;
        logic [15:0] e_pc;
        logic [8:0]  e_ins;
        bit          e_hlt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit redir, logic [15:0] tgt, bit halt, bit rdy,
                                bit e_req, logic [15:0] e_addr, bit e_val,
                                logic [15:0] e_pc, logic [8:0] e_ins, bit e_hlt);
        vec_t v;
        v.rst = rst; v.redir = redir; v.tgt = tgt; v.halt = halt; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
        v.e_pc = e_pc; v.e_ins = e_ins; v.e_hlt = e_hlt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d, t=%0t): got %0h expected %0h", name, vidx, $time, act, exp);
        end
    endtask

    // Holds reset across a clock edge, checks reset outputs, releases on a falling edge.
    task automatic do_reset();
        init_n = 1'b0;
        redirect = 1'b0;
        halt_in = 1'b0;
        instr_ready = 1'b0;
        redirect_target = '0;
        @(posedge CLK);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_imem_addr", imem_addr, 0);
        @(negedge CLK);
        init_n = 1'b1;
    endtask

    initial begin
        //        rst redir tgt       halt rdy  req addr      val pc        ins     hlt
        // Streaming from reset, then redirect to 0x40 with a request in flight
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1,  1, 16'h0000, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0001, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0002, 1, 16'h0000, 9'h010, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0003, 1, 16'h0001, 9'h011, 0));
        vecs.push_back(mk(0, 1, 16'h0040, 0, 1,  0, 16'h0004, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0040, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0041, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0042, 1, 16'h0040, 9'h050, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0043, 1, 16'h0041, 9'h051, 0));
        // Consumer stalled for 5 cycles: exactly two requests, then in-order drain
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0,  1, 16'h0000, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h0001, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  0, 16'h0002, 1, 16'h0000, 9'h010, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  0, 16'h0002, 1, 16'h0000, 9'h010, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  0, 16'h0002, 1, 16'h0000, 9'h010, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0002, 1, 16'h0000, 9'h010, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0003, 1, 16'h0001, 9'h011, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0004, 1, 16'h0002, 9'h012, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0005, 1, 16'h0003, 9'h013, 0));
        // Halt with one queued and one in flight; redirect in HALT must not restart fetch
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1,  1, 16'h0000, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0001, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0002, 1, 16'h0000, 9'h010, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1,  0, 16'h0003, 1, 16'h0001, 9'h011, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0003, 1, 16'h0002, 9'h012, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0003, 0, 16'h0000, 9'h000, 1));
        vecs.push_back(mk(0, 1, 16'h0100, 0, 1,  0, 16'h0003, 0, 16'h0000, 9'h000, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0100, 0, 16'h0000, 9'h000, 1));
        // Address wrap FFFF -> 0000
        vecs.push_back(mk(1, 1, 16'hFFFF, 0, 1,  0, 16'h0000, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'hFFFF, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0000, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0001, 1, 16'hFFFF, 9'h00F, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0002, 1, 16'h0000, 9'h010, 0));
        // Back-to-back redirects: the last target wins
        vecs.push_back(mk(1, 1, 16'h0020, 0, 1,  0, 16'h0000, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 1, 16'h0030, 0, 1,  0, 16'h0020, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0030, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0031, 0, 16'h0000, 9'h000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  1, 16'h0032, 1, 16'h0030, 9'h040, 0));

        #3;
        foreach (vecs[i]) begin
            vidx = i;
            if (vecs[i].rst)
                do_reset();
            else
                @(negedge CLK);
            redirect        = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            halt_in         = vecs[i].halt;
            instr_ready     = vecs[i].rdy;
            #1;
            chk("imem_req", imem_req, vecs[i].e_req);
            chk("imem_addr", imem_addr, vecs[i].e_addr);
            chk("instr_valid", instr_valid, vecs[i].e_val);
            chk("halted", halted, vecs[i].e_hlt);
            if (vecs[i].e_val) begin
                chk("instr_pc", instr_pc, vecs[i].e_pc);
                chk("instr", instr, vecs[i].e_ins);
            end
        end

        // Short reset pulse mid-stream, entirely within the low clock phase
        vidx = -2;
        do_reset();
        instr_ready = 1'b1;
        #1;
        chk("pulse_first_req", imem_req, 1);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("pulse_pre_valid", instr_valid, 1);
        chk("pulse_pre_pc", instr_pc, 16'h0000);
        #1;
        init_n = 1'b0;
        #1;
        chk("pulse_valid_low", instr_valid, 0);
        chk("pulse_req_low", imem_req, 0);
        chk("pulse_instr", instr, 0);
        chk("pulse_instr_pc", instr_pc, 0);
        chk("pulse_addr", imem_addr, 0);
        #1;
        init_n = 1'b1;
        #1;
        chk("pulse_restart_req", imem_req, 1);
        chk("pulse_restart_addr", imem_addr, 16'h0000);
        chk("pulse_restart_valid", instr_valid, 0);
        @(negedge CLK);
        #1;
        chk("pulse_c1_addr", imem_addr, 16'h0001);
        chk("pulse_c1_valid", instr_valid, 0);
        @(negedge CLK);
        #1;
        chk("pulse_c2_valid", instr_valid, 1);
        chk("pulse_c2_pc", instr_pc, 16'h0000);
        chk("pulse_c2_instr", instr, 9'h010);
        chk("pulse_c2_addr", imem_addr, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
